// File: rtl/traffic_ctrl_rr.sv
// N-road round-robin traffic-light controller: min/max green, yellow and all-red clearance, idle rest on road 0.
// Defining PREEMPT_EN adds the preempt/preempt_road override ports.
module traffic_ctrl_rr #(
    parameter int N_ROADS   = 2,
    parameter int CNT_W     = 8,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 16,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_ROADS-1:0]         car,
`ifdef PREEMPT_EN
    input  logic                       preempt,
    input  logic [$clog2(N_ROADS)-1:0] preempt_road,
`endif
    output logic [3*N_ROADS-1:0]       light,
    output logic [$clog2(N_ROADS)-1:0] active_road,
    output logic [1:0]                 phase,
    output logic [N_ROADS-1:0]         req
);
    localparam int AW = $clog2(N_ROADS);
    localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_M1  = CNT_W'(ALL_RED - 1);
    localparam logic [3*N_ROADS-1:0] LIGHT_RST = {{(N_ROADS-1){3'b001}}, 3'b100};

    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALL_RED = 2'b10
    } phase_t;

    phase_t               phase_q, phase_n;
    logic [AW-1:0]        active_n, next_road, next_road_n;
    logic [AW-1:0]        rr_road, rr_idx, pre_road;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [N_ROADS-1:0]   req_n;
    logic [3*N_ROADS-1:0] light_n;
    logic                 rr_found, pre_on;

    assign phase = phase_q;

`ifdef PREEMPT_EN
    assign pre_on   = preempt;
    assign pre_road = preempt_road;
`else
    assign pre_on   = 1'b0;
    assign pre_road = '0;
`endif

    // Round-robin pick: nearest pending road after the current one, scanning far-to-near so the nearest wins.
    always_comb begin
        rr_road  = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = N_ROADS - 1; k >= 1; k--) begin
            rr_idx = AW'((int'(active_road) + k) % N_ROADS);
            if (req[rr_idx]) begin
                rr_road  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        phase_n     = phase_q;
        active_n    = active_road;
        next_road_n = next_road;
        req_n       = req;
        light_n     = '0;

        for (int i = 0; i < N_ROADS; i++) begin
            if (car[i] && (phase_q != PH_GREEN || AW'(i) != active_road)) begin
                req_n[i] = 1'b1;
            end
        end

        case (phase_q)
            PH_GREEN: begin
                if (pre_on) begin
                    if (pre_road != active_road) begin
                        phase_n     = PH_YELLOW;
                        next_road_n = pre_road;
                    end
                end else if (rr_found && (cnt >= MIN_M1 || cnt >= MAX_M1)) begin
                    phase_n     = PH_YELLOW;
                    next_road_n = rr_road;
                end else if (req == '0 && active_road != '0 && cnt >= MIN_M1) begin
                    phase_n     = PH_YELLOW;
                    next_road_n = '0;
                end
            end
            PH_YELLOW: begin
                if (cnt >= YEL_M1) begin
                    phase_n = PH_ALL_RED;
                end
            end
            PH_ALL_RED: begin
                if (cnt >= AR_M1) begin
                    phase_n        = PH_GREEN;
                    active_n       = pre_on ? pre_road : next_road;
                    req_n[active_n] = 1'b0;
                end
            end
            default: begin
                phase_n = PH_GREEN;
            end
        endcase

        // The counter restarts on every phase entry and otherwise saturates.
        if (phase_n != phase_q) begin
            cnt_n = '0;
        end else if (&cnt) begin
            cnt_n = cnt;
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end

        for (int i = 0; i < N_ROADS; i++) begin
            if (phase_n == PH_GREEN && AW'(i) == active_n) begin
                light_n[3*i +: 3] = 3'b100;
            end else if (phase_n == PH_YELLOW && AW'(i) == active_n) begin
                light_n[3*i +: 3] = 3'b010;
            end else begin
                light_n[3*i +: 3] = 3'b001;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= PH_GREEN;
            active_road <= '0;
            next_road   <= '0;
            cnt         <= '0;
            req         <= '0;
            light       <= LIGHT_RST;
        end else begin
            phase_q     <= phase_n;
            active_road <= active_n;
            next_road   <= next_road_n;
            cnt         <= cnt_n;
            req         <= req_n;
            light       <= light_n;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_rr.sv
// Self-checking bench for traffic_ctrl_rr (N_ROADS=4): directed scenarios plus random car traffic
// checked against a timeline-based reference model.
`timescale 1ns/1ps
module tb_traffic_ctrl_rr;
    localparam int N   = 4;
    localparam int MIN = 4;
    localparam int MAX = 16;
    localparam int YEL = 2;
    localparam int AR  = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   car;
    logic [3*N-1:0] light;
    logic [1:0]     active_road;
    logic [1:0]     phase;
    logic [N-1:0]   req;
`ifdef PREEMPT_EN
    logic           preempt = 1'b0;
    logic [1:0]     preempt_road = 2'd0;
`endif

    traffic_ctrl_rr #(
        .N_ROADS(N), .CNT_W(8), .MIN_GREEN(MIN), .MAX_GREEN(MAX), .YELLOW(YEL), .ALL_RED(AR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .car(car),
`ifdef PREEMPT_EN
        .preempt(preempt),
        .preempt_road(preempt_road),
`endif
        .light(light),
        .active_road(active_road),
        .phase(phase),
        .req(req)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: absolute cycle index, current owner, cycle its green began, cycle yellow starts (-1 = none).
    int           m_cyc, m_cur, m_since, m_switch, m_target;
    logic [N-1:0] m_pend;

    function automatic int modelPhase();
        if (m_switch < 0 || m_cyc < m_switch) return 0;
        if (m_cyc < m_switch + YEL) return 1;
        return 2;
    endfunction

    function automatic logic [3*N-1:0] expLight();
        logic [3*N-1:0] l;
        int ph;
        ph = modelPhase();
        for (int i = 0; i < N; i++) begin
            if (ph == 0 && i == m_cur)      l[3*i +: 3] = 3'b100;
            else if (ph == 1 && i == m_cur) l[3*i +: 3] = 3'b010;
            else                            l[3*i +: 3] = 3'b001;
        end
        return l;
    endfunction

    function automatic int rrPick(logic [N-1:0] pend);
        for (int k = 1; k < N; k++) begin
            if (pend[(m_cur + k) % N]) return (m_cur + k) % N;
        end
        return m_cur;
    endfunction

    task automatic resetModel();
        m_cyc = 0; m_cur = 0; m_since = 0; m_switch = -1; m_target = 0; m_pend = '0;
    endtask

    task automatic modelStep(input logic [N-1:0] car_v);
        int           ph;
        logic [N-1:0] old;
        ph  = modelPhase();
        old = m_pend;
        for (int i = 0; i < N; i++) begin
            if (car_v[i] && (ph != 0 || i != m_cur)) m_pend[i] = 1'b1;
        end
        if (ph == 0 && m_switch < 0 && (m_cyc - m_since) >= MIN - 1) begin
            if (old != '0) begin
                m_target = rrPick(old);
                m_switch = m_cyc + 1;
            end else if (m_cur != 0) begin
                m_target = 0;
                m_switch = m_cyc + 1;
            end
        end
        m_cyc++;
        if (m_switch >= 0 && m_cyc == m_switch + YEL + AR) begin
            m_cur         = m_target;
            m_since       = m_cyc;
            m_switch      = -1;
            m_pend[m_cur] = 1'b0;
        end
    endtask

    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic checkOutput();
        checkField("phase", 32'(phase), 32'(modelPhase()));
        checkField("active_road", 32'(active_road), 32'(m_cur));
        checkField("req", 32'(req), 32'(m_pend));
        checkField("light", 32'(light), 32'(expLight()));
    endtask

    task automatic applyStimulus(input logic [N-1:0] v);
        @(negedge clk);
        car = v;
        @(posedge clk);
        modelStep(v);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        car   = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        resetModel();
        checkOutput();
    endtask

    initial begin
        logic found;
        car   = '0;
        rst_n = 1'b0;
        resetModel();

        // Reset values and a long idle stretch resting on road 0.
        doReset();
        checkField("rst_light", 32'(light), 32'(12'b001001001100));
        for (int k = 0; k < 50; k++) applyStimulus('0);
        checkField("idle_light", 32'(light), 32'(12'b001001001100));
        checkField("idle_req", 32'(req), 32'(0));

        // Single-cycle pulse on road 1, then idle return to road 0.
        doReset();
        applyStimulus(4'b0010);
        for (int k = 0; k < 14; k++) begin
            applyStimulus('0);
            if (m_cyc == 4)  checkField("pulse_yellow4", 32'(phase), 32'(1));
            if (m_cyc == 6)  checkField("pulse_allred6", 32'(light), 32'(12'b001001001001));
            if (m_cyc == 7)  checkField("pulse_road1_at7", 32'(active_road), 32'(1));
            if (m_cyc == 14) checkField("pulse_back0_at14", 32'(light), 32'(12'b001001001100));
        end

        // Roads 1 and 3 held: 0 -> 1 -> 3 spaced 7 cycles apart.
        doReset();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(4'b1010);
            if (m_cyc == 7)  checkField("held_road1_at7", 32'(active_road), 32'(1));
            if (m_cyc == 14) checkField("held_road3_light", 32'(light), 32'(12'b100001001001));
        end

        // Late request on road 2 after road 0 has been green past MIN_GREEN.
        doReset();
        for (int k = 0; k < 10; k++) applyStimulus('0);
        applyStimulus(4'b0100);
        applyStimulus('0);
        checkField("late_req_yellow", 32'(phase), 32'(1));
        for (int k = 0; k < 4; k++) applyStimulus('0);
        checkField("late_req_road2", 32'(active_road), 32'(2));

        // Random traffic.
        doReset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) applyStimulus('0);
            else applyStimulus(N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
        end

        // Asynchronous reset in the middle of a yellow phase.
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            applyStimulus(N'($urandom_range(1, 15)));
            if (modelPhase() == 1) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $error("[TB] FAIL yellow_wait: observed no yellow expected yellow within 200 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkField("async_rst_phase", 32'(phase), 32'(0));
        checkField("async_rst_road", 32'(active_road), 32'(0));
        checkField("async_rst_req", 32'(req), 32'(0));
        checkField("async_rst_light", 32'(light), 32'(12'b001001001100));
        car   = '0;
        rst_n = 1'b1;
        resetModel();

        for (int k = 0; k < 150; k++) applyStimulus(N'($urandom_range(0, 15)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
